// File: rtl/simd_alu_pkg.sv
// Shared constants and helpers for the segmented SIMD post-adder ALU.
// Holds the ALUMODE codes, the USE_SIMD lane groupings and the
// lane-size helper used to find lane boundaries.
package simd_alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b1100;
    localparam logic [3:0] ALU_OR  = 4'b1110;

    typedef enum logic [1:0] {
        SIMD_ONE  = 2'd0,
        SIMD_TWO  = 2'd1,
        SIMD_FOUR = 2'd2,
        SIMD_SEG  = 2'd3
    } use_simd_e;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_XOR,
        OP_AND,
        OP_OR
    } alu_op_e;

    // Number of segments grouped into one lane for a USE_SIMD setting.
    function automatic int unsigned lane_seg_count(input logic [1:0] use_simd,
                                                   input int unsigned num_seg);
        case (use_simd)
            SIMD_ONE:  return num_seg;
            SIMD_TWO:  return num_seg / 2;
            SIMD_FOUR: return num_seg / 4;
            default:   return 1;
        endcase
    endfunction

    // Unknown ALUMODE codes fall back to addition.
    function automatic alu_op_e decode_op(input logic [3:0] alumode);
        case (alumode)
            ALU_ADD: return OP_ADD;
            ALU_SUB: return OP_SUB;
            ALU_XOR: return OP_XOR;
            ALU_AND: return OP_AND;
            ALU_OR:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/simd_alu_seg.sv
// One carry segment of the SIMD ALU.
// First folds W+X+Y plus the incoming T carry (0..2) into a segment of T,
// then adds T to Z or subtracts it from Z with a single-bit carry/borrow.
// The T carry and the result carry form the pair handed to the next slice.
module simd_alu_seg #(
    parameter int SEG_W = 9
) (
    input  logic [SEG_W-1:0] w,
    input  logic [SEG_W-1:0] x,
    input  logic [SEG_W-1:0] y,
    input  logic [SEG_W-1:0] z,
    input  logic             sub,
    input  logic [1:0]       t_cin,
    input  logic             r_cin,
    output logic [1:0]       t_cout,
    output logic             r_cout,
    output logic [SEG_W-1:0] r
);

    logic [SEG_W+1:0] t_full;
    logic [SEG_W-1:0] t_seg;
    logic [SEG_W:0]   r_full;

    // Three operands plus a carry of up to 2 never exceed two carry bits.
    always_comb begin
        t_full = {2'b00, w} + {2'b00, x} + {2'b00, y} + {{SEG_W{1'b0}}, t_cin};
        t_seg  = t_full[SEG_W-1:0];
        t_cout = t_full[SEG_W+1:SEG_W];
    end

    // Top bit of the widened sum is the carry; for subtraction it is the borrow.
    always_comb begin
        if (sub) begin
            r_full = {1'b0, z} - {1'b0, t_seg} - {{SEG_W{1'b0}}, r_cin};
        end else begin
            r_full = {1'b0, z} + {1'b0, t_seg} + {{SEG_W{1'b0}}, r_cin};
        end
        r      = r_full[SEG_W-1:0];
        r_cout = r_full[SEG_W];
    end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage pipelined SIMD ALU for the DSP post-adder stage.
// Stage 1 registers operands and controls; stage 2 computes the lane
// results, carries and the accumulate feedback, and registers them.
// Optional macro SIMD_ALU_OVF_STICKY_EN adds the sticky ovf_flags port.
module simd_alu_pipe
    import simd_alu_pkg::*;
#(
    parameter  int SEG_W   = 9,
    parameter  int NUM_SEG = 8,
    localparam int TOT_W   = SEG_W * NUM_SEG
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [3:0]         ALUMODE,
    input  logic [1:0]         USE_SIMD,
    input  logic               ACC,
    input  logic               CIN,
    input  logic [TOT_W-1:0]   W,
    input  logic [TOT_W-1:0]   X,
    input  logic [TOT_W-1:0]   Y,
    input  logic [TOT_W-1:0]   Z,
    input  logic               clr_ovf,
    output logic               out_valid,
    output logic [TOT_W-1:0]   S,
    output logic [NUM_SEG-1:0] carry_out
`ifdef SIMD_ALU_OVF_STICKY_EN
    ,
    output logic [NUM_SEG-1:0] ovf_flags
`endif
);

    logic               v1;
    logic [3:0]         mode1;
    logic [1:0]         simd1;
    logic               acc1;
    logic               cin1;
    logic [TOT_W-1:0]   w1;
    logic [TOT_W-1:0]   x1;
    logic [TOT_W-1:0]   y1;
    logic [TOT_W-1:0]   z1;

    alu_op_e            op2;
    int unsigned        lane_mask;
    logic [TOT_W-1:0]   z_eff;
    logic [TOT_W-1:0]   arith;
    logic [NUM_SEG-1:0] seg_carry;
    logic [TOT_W-1:0]   s_next;
    logic [NUM_SEG-1:0] carry_next;

    // Stage-1 valid; reset discards whatever was accepted this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
        end
    end

    // Stage-1 operand and control capture for each accepted operation.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mode1 <= ALUMODE;
            simd1 <= USE_SIMD;
            acc1  <= ACC;
            cin1  <= CIN;
            w1    <= W;
            x1    <= X;
            y1    <= Y;
            z1    <= Z;
        end
    end

    // Decode the operation, lane size and accumulate source for stage 2.
    always_comb begin
        op2       = decode_op(mode1);
        lane_mask = lane_seg_count(simd1, NUM_SEG) - 1;
        z_eff     = acc1 ? S : z1;
    end

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
        logic [1:0] t_ci;
        logic [1:0] t_co;
        logic       r_ci;
        logic       r_co;

        if (k == 0) begin : g_first
            assign t_ci = {1'b0, cin1};
            assign r_ci = 1'b0;
        end else begin : g_next
            assign t_ci = ((32'(k) & lane_mask) == 32'd0) ? {1'b0, cin1} : g_seg[k-1].t_co;
            assign r_ci = ((32'(k) & lane_mask) == 32'd0) ? 1'b0 : g_seg[k-1].r_co;
        end

        simd_alu_seg #(.SEG_W(SEG_W)) u_seg (
            .w      (w1[k*SEG_W +: SEG_W]),
            .x      (x1[k*SEG_W +: SEG_W]),
            .y      (y1[k*SEG_W +: SEG_W]),
            .z      (z_eff[k*SEG_W +: SEG_W]),
            .sub    (op2 == OP_SUB),
            .t_cin  (t_ci),
            .r_cin  (r_ci),
            .t_cout (t_co),
            .r_cout (r_co),
            .r      (arith[k*SEG_W +: SEG_W])
        );

        assign seg_carry[k] = ((32'(k) & lane_mask) == lane_mask) & ((|t_co) | r_co);
    end

    // Pick the lane arithmetic or a bitwise op; bitwise ops never carry.
    always_comb begin
        s_next     = arith;
        carry_next = seg_carry;
        case (op2)
            OP_XOR: begin
                s_next     = x1 ^ z_eff;
                carry_next = '0;
            end
            OP_AND: begin
                s_next     = x1 & z_eff;
                carry_next = '0;
            end
            OP_OR: begin
                s_next     = x1 | z_eff;
                carry_next = '0;
            end
            default: begin
                s_next     = arith;
                carry_next = seg_carry;
            end
        endcase
    end

    // Stage-2 result register; S and carry_out hold across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            S         <= '0;
            carry_out <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                S         <= s_next;
                carry_out <= carry_next;
            end
        end
    end

`ifdef SIMD_ALU_OVF_STICKY_EN
    // Sticky lane overflow; a new overflow beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_flags <= '0;
        end else begin
            ovf_flags <= (ovf_flags & ~{NUM_SEG{clr_ovf}}) | (v1 ? carry_next : '0);
        end
    end
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = clr_ovf;
`endif

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Self-checking bench for simd_alu_pipe (SEG_W=9, NUM_SEG=8).
// A lane-level arithmetic model predicts each result and its arrival time.
module tb_simd_alu_pipe;

    localparam int SEG_W   = 9;
    localparam int NUM_SEG = 8;
    localparam int TOT_W   = 72;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [3:0]         ALUMODE;
    logic [1:0]         USE_SIMD;
    logic               ACC;
    logic               CIN;
    logic [TOT_W-1:0]   W, X, Y, Z;
    logic               clr_ovf;
    logic               out_valid;
    logic [TOT_W-1:0]   S;
    logic [NUM_SEG-1:0] carry_out;
`ifdef SIMD_ALU_OVF_STICKY_EN
    logic [NUM_SEG-1:0] ovf_flags;
`endif

    simd_alu_pipe #(.SEG_W(SEG_W), .NUM_SEG(NUM_SEG)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .ALUMODE   (ALUMODE),
        .USE_SIMD  (USE_SIMD),
        .ACC       (ACC),
        .CIN       (CIN),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .S         (S),
        .carry_out (carry_out)
`ifdef SIMD_ALU_OVF_STICKY_EN
        ,
        .ovf_flags (ovf_flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [TOT_W-1:0] s;
        logic [7:0]      c;
    } exp_t;

    exp_t             pending[$];
    int               total = 0;
    int               bad   = 0;
    int               cyc   = 0;
    logic [TOT_W-1:0] last_s = '0;
    logic [TOT_W-1:0] held_s = '0;
    logic [7:0]       held_c = '0;
    logic [7:0]       ovf_m  = '0;
    logic             pend_clr = 1'b0;

    // Lane-by-lane reference computed with wide plain arithmetic.
    function automatic void model(input logic [3:0] m, input logic [1:0] simd, input logic c_in,
                                  input logic [TOT_W-1:0] w, input logic [TOT_W-1:0] x,
                                  input logic [TOT_W-1:0] y, input logic [TOT_W-1:0] z,
                                  output logic [TOT_W-1:0] s, output logic [7:0] c);
        int g, l;
        logic [127:0] mask, wl, xl, yl, zl, t, full, res;
        s = '0;
        c = '0;
        g = (simd == 2'd0) ? 8 : (simd == 2'd1) ? 4 : (simd == 2'd2) ? 2 : 1;
        l = g * SEG_W;
        if (m == 4'b0100) s = x ^ z;
        else if (m == 4'b1100) s = x & z;
        else if (m == 4'b1110) s = x | z;
        else begin
            mask = (128'd1 << l) - 128'd1;
            for (int j = 0; j < NUM_SEG / g; j++) begin
                wl = ({56'd0, w} >> (j * l)) & mask;
                xl = ({56'd0, x} >> (j * l)) & mask;
                yl = ({56'd0, y} >> (j * l)) & mask;
                zl = ({56'd0, z} >> (j * l)) & mask;
                t  = wl + xl + yl + 128'(c_in);
                if (m == 4'b0011) begin
                    res = (zl - t) & mask;
                    c[j*g + g - 1] = (zl < t);
                end else begin
                    full = zl + t;
                    res  = full & mask;
                    c[j*g + g - 1] = (full > mask);
                end
                s = s | TOT_W'(res << (j * l));
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [TOT_W-1:0] obs, input logic [TOT_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic exp_v;
        exp_v = (pending.size() > 0) && (pending[0].due == cyc);
        if (exp_v) begin
            held_s = pending[0].s;
            held_c = pending[0].c;
            void'(pending.pop_front());
        end
        if (pend_clr) ovf_m = '0;
        if (exp_v) ovf_m = ovf_m | held_c;
        chk("out_valid", TOT_W'(out_valid), TOT_W'(exp_v));
        chk("S", S, held_s);
        chk("carry_out", TOT_W'(carry_out), TOT_W'(held_c));
`ifdef SIMD_ALU_OVF_STICKY_EN
        chk("ovf_flags", TOT_W'(ovf_flags), TOT_W'(ovf_m));
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] m, input logic [1:0] simd,
                                 input logic acc, input logic cin, input logic [TOT_W-1:0] w,
                                 input logic [TOT_W-1:0] x, input logic [TOT_W-1:0] y,
                                 input logic [TOT_W-1:0] z, input logic clr);
        exp_t e;
        in_valid = v; ALUMODE = m; USE_SIMD = simd; ACC = acc; CIN = cin;
        W = w; X = x; Y = y; Z = z; clr_ovf = clr;
        pend_clr = clr;
        if (v) begin
            model(m, simd, cin, w, x, y, acc ? last_s : z, e.s, e.c);
            e.due = cyc + 2;
            last_s = e.s;
            pending.push_back(e);
        end
        @(posedge clk); #1;
        cyc++;
        checkOutput();
    endtask

    task automatic idle(input logic clr);
        applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, '0, '0, '0, '0, clr);
    endtask

    // Reset with in_valid held high to show reset wins.
    task automatic doReset();
        reset = 1'b1; in_valid = 1'b1; clr_ovf = 1'b0;
        @(posedge clk); #1;
        cyc++;
        reset = 1'b0; in_valid = 1'b0;
        pending.delete();
        last_s = '0; held_s = '0; held_c = '0; ovf_m = '0; pend_clr = 1'b0;
        checkOutput();
    endtask

    initial begin
        logic [TOT_W-1:0] rw, rx, ry, rz;
        logic [3:0]       rm;
        reset = 1'b1; in_valid = 1'b0; ALUMODE = '0; USE_SIMD = '0; ACC = 1'b0; CIN = 1'b0;
        W = '0; X = '0; Y = '0; Z = '0; clr_ovf = 1'b0;
        @(posedge clk); #1;
        cyc++;
        doReset();

        // Scenario 1: single-lane add with carry-in.
        applyStimulus(1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 72'd1, 72'd2, 72'd3, 72'd4, 1'b0);
        idle(1'b0);
        chk("tp1_S", S, 72'd11);
        chk("tp1_valid", TOT_W'(out_valid), 72'd1);
        idle(1'b0);
        chk("tp1_pulse", TOT_W'(out_valid), 72'd0);

        // Scenario 2: per-segment lanes all overflow, no leakage.
        applyStimulus(1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, {8{9'd1}}, '0, '0, {8{9'h1FF}}, 1'b0);
        idle(1'b0);
        chk("tp2_S", S, 72'd0);
        chk("tp2_carry", TOT_W'(carry_out), 72'hFF);
`ifdef SIMD_ALU_OVF_STICKY_EN
        chk("tp2_ovf", TOT_W'(ovf_flags), 72'hFF);
`endif

        // Scenario 3: 18-bit lane subtract with borrow.
        applyStimulus(1'b1, 4'b0011, 2'd2, 1'b0, 1'b0, {4{18'd7}}, '0, '0, {4{18'd5}}, 1'b0);
        idle(1'b0);
        chk("tp3_S", S, {4{18'h3FFFE}});
        chk("tp3_carry", TOT_W'(carry_out), 72'hAA);

        // Scenario 4: accumulate across a bubble.
        doReset();
        applyStimulus(1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 72'd1, '0, '0, 72'h123, 1'b0);
        applyStimulus(1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 72'd1, '0, '0, 72'h123, 1'b0);
        idle(1'b0);
        applyStimulus(1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 72'd1, '0, '0, 72'h123, 1'b0);
        applyStimulus(1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 72'd1, '0, '0, 72'h123, 1'b0);
        idle(1'b0);
        chk("tp4_S", S, 72'd4);

        // Scenario 5: reset right after an accepted operation.
        applyStimulus(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 72'd9, '0, '0, 72'd9, 1'b0);
        doReset();
        idle(1'b0);
        chk("tp5_valid", TOT_W'(out_valid), 72'd0);
        chk("tp5_S", S, 72'd0);

        // Scenario 6: clear collides with a new overflow, then clear alone.
        applyStimulus(1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, {8{9'd1}}, '0, '0, {8{9'h1FF}}, 1'b0);
        idle(1'b1);
`ifdef SIMD_ALU_OVF_STICKY_EN
        chk("tp6_setwins", TOT_W'(ovf_flags), 72'hFF);
`endif
        idle(1'b1);
`ifdef SIMD_ALU_OVF_STICKY_EN
        chk("tp6_clear", TOT_W'(ovf_flags), 72'd0);
`endif

        // Randomised mix of modes, lane sizes, accumulate and bubbles.
        for (int i = 0; i < 300; i++) begin
            rw = TOT_W'({$urandom(), $urandom(), $urandom()});
            rx = TOT_W'({$urandom(), $urandom(), $urandom()});
            ry = TOT_W'({$urandom(), $urandom(), $urandom()});
            rz = TOT_W'({$urandom(), $urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) rz = '1;
            if ($urandom_range(0, 3) == 0) begin rx = '0; ry = '0; end
            case ($urandom_range(0, 5))
                0: rm = 4'b0000;
                1: rm = 4'b0011;
                2: rm = 4'b0100;
                3: rm = 4'b1100;
                4: rm = 4'b1110;
                default: rm = 4'($urandom());
            endcase
            if ($urandom_range(0, 79) == 0) doReset();
            else applyStimulus($urandom_range(0, 3) != 0, rm, 2'($urandom()), 1'($urandom()),
                               1'($urandom()), rw, rx, ry, rz, $urandom_range(0, 9) == 0);
        end
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
